// File: rtl/status_register_pkg.sv
// rtl/status_register_pkg.sv - shared flag indices, flag vector type and stack depth default
package status_register_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int DEPTH_DEFAULT = 4;

  typedef logic [3:0] flags_t;

  // Per-bit select: mask=1 takes the update value, mask=0 keeps the current one.
  function automatic flags_t merge_flags(flags_t cur, flags_t upd, flags_t mask);
    return (cur & ~mask) | (upd & mask);
  endfunction

endpackage

// File: rtl/flag_stack.sv
// rtl/flag_stack.sv - shadow flag LIFO with push, pop, swap and occupancy counter
module flag_stack
  import status_register_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int DW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  flags_t        din,
  output flags_t        top,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);

  flags_t        mem [DEPTH];
  logic          do_push;
  logic          do_pop;
  logic          do_swap;
  logic          do_write;
  logic [AW-1:0] top_ptr;
  logic [AW-1:0] wr_ptr;

  assign full  = (depth == DW'(DEPTH));
  assign empty = (depth == '0);

  // push+pop on an empty stack degrades to a plain push
  assign do_swap  = push & pop & ~empty;
  assign do_push  = push & ~full & ~do_swap;
  assign do_pop   = pop & ~push & ~empty;
  assign do_write = do_push | do_swap;

  assign top_ptr = AW'(depth - DW'(1));
  assign wr_ptr  = do_swap ? top_ptr : AW'(depth);
  assign top     = mem[top_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      depth <= '0;
    end else if (do_push) begin
      depth <= depth + DW'(1);
    end else if (do_pop) begin
      depth <= depth - DW'(1);
    end
  end

  // Storage is unreset; entries at or above depth are unreachable.
  always_ff @(posedge clock) begin
    if (!reset && do_write) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/status_register.sv
// rtl/status_register.sv - live NZCV flags with ALU/direct-write/restore priority and sticky stack errors
module status_register
  import status_register_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          alu_update,
  input  logic [3:0]    alu_mask,
  input  logic [3:0]    alu_flags,
  input  logic          wr_en,
  input  logic [3:0]    wr_flags,
  input  logic          push,
  input  logic          pop,
  input  logic          err_clear,
  output logic          Neg,
  output logic          Zer,
  output logic          Carry,
  output logic          V,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty,
  output logic          ovf_err,
  output logic          udf_err
);

  flags_t live;
  flags_t live_nxt;
  flags_t stack_top;
  logic   restore;
  logic   ovf_evt;
  logic   udf_evt;

  flag_stack #(
    .DEPTH(DEPTH)
  ) u_stack (
    .clock(clock),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (live),
    .top  (stack_top),
    .depth(depth),
    .full (full),
    .empty(empty)
  );

  assign restore = pop & ~empty;
  assign ovf_evt = push & ~pop & full;
  assign udf_evt = pop & ~push & empty;

  always_comb begin
    live_nxt = live;
    if (restore) begin
      live_nxt = stack_top;
    end else if (wr_en) begin
      live_nxt = wr_flags;
    end else if (alu_update) begin
      live_nxt = merge_flags(live, alu_flags, alu_mask);
    end
  end

  // A new error event outranks err_clear in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      live    <= '0;
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      live    <= live_nxt;
      ovf_err <= ovf_evt | (ovf_err & ~err_clear);
      udf_err <= udf_evt | (udf_err & ~err_clear);
    end
  end

  assign Neg   = live[FLAG_N];
  assign Zer   = live[FLAG_Z];
  assign Carry = live[FLAG_C];
  assign V     = live[FLAG_V];

endmodule
